// File: rtl/sw_seg_scan.sv
// Four-digit multiplexed 7-segment scan driver. The digit values are captured once per frame,
// each digit slot starts with a dead-time blank, and leading zeros can optionally be hidden.
module sw_seg_scan #(
    parameter int SCAN_DIV  = 100000,
    parameter int BLANK_CYC = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        EN,
    input  logic [15:0] DIGITS,
    input  logic [3:0]  DP,
    input  logic        LZ_SUPPRESS,
    output logic [11:0] SEG,
    output logic        FRAME
);

    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    idx_q, idx_d;
    logic [15:0]   dsnap_q, dsnap_d;
    logic [3:0]    dpsnap_q, dpsnap_d;
    logic [11:0]   seg_q, seg_d;
    logic          frame_q, frame_d;

    logic [3:0]    zero_above;
    logic [3:0]    cur_digit;
    logic          suppress;

    // zero_above[i] is set when snapshot digits i..3 are all zero.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lz
            assign zero_above[gi] = (dsnap_q[15:4*gi] == '0);
        end
    endgenerate

    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] r;
        case (v)
            4'h0: r = 7'h40;
            4'h1: r = 7'h79;
            4'h2: r = 7'h24;
            4'h3: r = 7'h30;
            4'h4: r = 7'h19;
            4'h5: r = 7'h12;
            4'h6: r = 7'h02;
            4'h7: r = 7'h78;
            4'h8: r = 7'h00;
            4'h9: r = 7'h10;
            4'hA: r = 7'h08;
            4'hB: r = 7'h03;
            4'hC: r = 7'h46;
            4'hD: r = 7'h21;
            4'hE: r = 7'h06;
            default: r = 7'h0E;
        endcase
        return r;
    endfunction

    assign cur_digit = dsnap_q[{idx_q, 2'b00} +: 4];
    assign suppress  = LZ_SUPPRESS && (idx_q != 2'd0) && zero_above[idx_q];

    always_comb begin
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        dsnap_d  = dsnap_q;
        dpsnap_d = dpsnap_q;
        seg_d    = 12'hFFF;
        frame_d  = 1'b0;
        if (EN) begin
            if (cnt_q == '0 && idx_q == 2'd3) begin
                dsnap_d  = DIGITS;
                dpsnap_d = DP;
                frame_d  = 1'b1;
            end
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                idx_d = idx_q - 2'd1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            // Outputs follow the pre-edge slot state, so the snapshot cycle is always blank.
            if (cnt_q >= CNT_BLANK && !suppress) begin
                seg_d = {~(4'b0001 << idx_q), ~dpsnap_q[idx_q], decode(cur_digit)};
            end
        end else begin
            cnt_d = '0;
            idx_d = 2'd3;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q    <= '0;
            idx_q    <= 2'd3;
            dsnap_q  <= 16'h0000;
            dpsnap_q <= 4'h0;
            seg_q    <= 12'hFFF;
            frame_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            dsnap_q  <= dsnap_d;
            dpsnap_q <= dpsnap_d;
            seg_q    <= seg_d;
            frame_q  <= frame_d;
        end
    end

    assign SEG   = seg_q;
    assign FRAME = frame_q;

endmodule

// File: tb/tb_sw_seg_scan.sv
// Bench for sw_seg_scan: a position-in-frame model predicts SEG/FRAME every cycle, with directed
// frames pinned to hand-decoded values followed by a randomized phase.
module tb_sw_seg_scan;

    localparam int SD = 8;
    localparam int BC = 2;
    localparam int FP = 4 * SD;
    localparam logic [6:0] SEG7 [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en = 1'b1;
    logic [15:0] digits = 16'h0000;
    logic [3:0]  dp = 4'h0;
    logic        lz = 1'b0;
    logic [11:0] seg;
    logic        frame;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model state: edges since the scan (re)started, plus the frame snapshot.
    int          m_run = 0;
    logic [15:0] m_snap = 16'h0000;
    logic [3:0]  m_dp = 4'h0;
    logic [11:0] m_seg = 12'hFFF;
    logic        m_frame = 1'b0;

    sw_seg_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
        .CLK(clk), .RESET(rst), .EN(en), .DIGITS(digits), .DP(dp),
        .LZ_SUPPRESS(lz), .SEG(seg), .FRAME(frame)
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] model_out(input int run, input logic [15:0] snap,
                                              input logic [3:0] dpm, input logic lzs);
        int pos = run % FP;
        int idx = 3 - pos / SD;
        int c   = pos % SD;
        logic [3:0] an = 4'hF;
        if (c < BC) return 12'hFFF;
        if (lzs && idx != 0 && (snap >> (4 * idx)) == 16'h0) return 12'hFFF;
        an[idx] = 1'b0;
        return {an, ~dpm[idx], SEG7[snap[4*idx +: 4]]};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_run <= 0; m_snap <= 16'h0; m_dp <= 4'h0; m_seg <= 12'hFFF; m_frame <= 1'b0;
        end else if (!en) begin
            m_run <= 0; m_seg <= 12'hFFF; m_frame <= 1'b0;
        end else begin
            m_frame <= (m_run % FP == 0);
            if (m_run % FP == 0) begin
                m_snap <= digits;
                m_dp   <= dp;
            end
            m_seg <= model_out(m_run, m_snap, m_dp, lz);
            m_run <= m_run + 1;
        end
    end

    task automatic tick();
        @(negedge clk);
        cyc++;
        checks++;
        if (seg !== m_seg) begin
            errors++;
            $display("FAIL seg_model cyc=%0d got=%h want=%h", cyc, seg, m_seg);
        end
        checks++;
        if (frame !== m_frame) begin
            errors++;
            $display("FAIL frame_model cyc=%0d got=%b want=%b", cyc, frame, m_frame);
        end
    endtask

    task automatic lit_seg(input string name, input logic [11:0] want);
        checks++;
        if (seg !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d seg got=%h want=%h", name, cyc, seg, want);
        end
    endtask

    task automatic lit_frame(input string name, input logic want);
        checks++;
        if (frame !== want) begin
            errors++;
            $display("FAIL %s cyc=%0d frame got=%b want=%b", name, cyc, frame, want);
        end
    endtask

    // Runs one aligned 32-cycle frame and pins FRAME and each slot's blank/drive values.
    task automatic frame_check(input string name, input logic [11:0] e3, input logic [11:0] e2,
                               input logic [11:0] e1, input logic [11:0] e0,
                               input int mid_at, input logic [15:0] mid_val);
        logic [47:0] ev = {e3, e2, e1, e0};
        for (int i = 0; i < FP; i++) begin
            if (i == mid_at) digits = mid_val;
            tick();
            if (i % SD == 0) lit_frame(name, i == 0);
            if (i % SD == 1) lit_seg(name, 12'hFFF);
            if (i % SD == 2 || i % SD == SD - 1) lit_seg(name, ev[12*(3 - i / SD) +: 12]);
        end
        $display("frame %s: checks=%0d errors=%0d", name, checks, errors);
    endtask

    initial begin
        logic [15:0] rd;
        for (int i = 0; i < 10; i++) begin
            tick();
            lit_seg("reset_seg", 12'hFFF);
            lit_frame("reset_frame", 1'b0);
        end
        digits = 16'h1234;
        rst = 1'b0;
        frame_check("plain_1234", 12'h7F9, 12'hBA4, 12'hDB0, 12'hE99, -1, 16'h0);
        dp = 4'b0010;
        frame_check("dp_digit1", 12'h7F9, 12'hBA4, 12'hD30, 12'hE99, -1, 16'h0);
        dp = 4'b0000; lz = 1'b1; digits = 16'h0007;
        frame_check("lz_0007", 12'hFFF, 12'hFFF, 12'hFFF, 12'hEF8, -1, 16'h0);
        digits = 16'h0000;
        frame_check("lz_0000", 12'hFFF, 12'hFFF, 12'hFFF, 12'hEC0, -1, 16'h0);
        digits = 16'h0400;
        frame_check("lz_0400", 12'hFFF, 12'hB99, 12'hDC0, 12'hEC0, -1, 16'h0);
        lz = 1'b0; digits = 16'h1234;
        frame_check("snap_hold", 12'h7F9, 12'hBA4, 12'hDB0, 12'hE99, 10, 16'h5678);
        frame_check("snap_next", 12'h792, 12'hB82, 12'hDF8, 12'hE80, -1, 16'h0);

        for (int i = 0; i < 20; i++) tick();
        lit_seg("pre_abort", 12'hDF8);
        en = 1'b0;
        tick();
        lit_seg("en_abort", 12'hFFF);
        lit_frame("en_abort", 1'b0);
        tick(); tick();
        en = 1'b1;
        frame_check("en_resume", 12'h792, 12'hB82, 12'hDF8, 12'hE80, -1, 16'h0);

        for (int i = 0; i < 20; i++) tick();
        rst = 1'b1;
        tick();
        lit_seg("rst_abort", 12'hFFF);
        rst = 1'b0;
        frame_check("rst_resume", 12'h792, 12'hB82, 12'hDF8, 12'hE80, -1, 16'h0);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 19) == 0) begin
                for (int k = 0; k < 4; k++)
                    rd[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
                digits = rd;
            end
            if ($urandom_range(0, 19) == 0) dp = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 39) == 0) lz = ~lz;
            en  = ($urandom_range(0, 63) != 0);
            rst = ($urandom_range(0, 299) == 0);
            tick();
        end
        $display("random phase: checks=%0d errors=%0d", checks, errors);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sw_seg_scan.md
# sw_seg_scan

Time-multiplexed 4-digit 7-segment scan driver for the stopwatch display path. Consumes the stopwatch's packed digit values and decimal-point mask and produces the 12-bit SEG bus: anode enables plus cathodes. Adds inter-digit blanking, per-frame snapshotting to prevent tearing, and optional leading-zero suppression.

## Interface
- SCAN_DIV, 100000 — clock cycles per digit slot; must be > BLANK_CYC
- BLANK_CYC, 16 — dead-time cycles at the start of each slot, all anodes off; must be >= 1
- CLK  in  1  system clock, all logic on rising edge
- RESET  in  1  synchronous, active-high reset
- EN  in  1  scan enable; low forces display dark and restarts the scan
- DIGITS  in  16  digit values; [15:12] = digit 3 (leftmost) … [3:0] = digit 0 (rightmost)
- DP  in  4  decimal-point request per digit, bit i = digit i, active-high
- LZ_SUPPRESS  in  1  1 = blank leading zeros
- SEG  out  12  {AN[3:0], DP_n, G_n, F_n, E_n, D_n, C_n, B_n, A_n}; all active-low; AN[i] selects digit i
- FRAME  out  1  one-cycle pulse marking the start of each scan frame (snapshot taken)

## Operation
- Registers: slot counter cnt (0..SCAN_DIV-1, width clog2(SCAN_DIV)), digit index idx (2 bits), snapshots dsnap[15:0] and dpsnap[3:0], SEG and FRAME output registers.
- Scan order: idx = 3, 2, 1, 0, 3, … When cnt == SCAN_DIV-1, cnt wraps to 0 and idx decrements mod 4 (0 wraps to 3).
- Snapshot: in any cycle with EN=1, cnt==0 and idx==3, load dsnap<=DIGITS and dpsnap<=DP, and set FRAME<=1 for the next cycle. DIGITS and DP are ignored at all other times.
- Slot phases:
  - BLANK: cnt < BLANK_CYC. SEG = 12'hFFF.
  - DRIVE: cnt >= BLANK_CYC. AN = ~(1<<idx). Cathodes = decode(dsnap digit idx). DP_n = ~dpsnap[idx].
- Decode (active-low, {G..A}): 0=7'h40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- Leading-zero suppression (LZ_SUPPRESS sampled live): digit i in 3..1 is suppressed if it and every more-significant digit in dsnap are zero. Digit 0 is never suppressed. A suppressed digit outputs SEG = 12'hFFF for its whole slot, including its DP.
- EN=0: cnt<=0, idx<=3, SEG<=12'hFFF, FRAME<=0. The snapshot registers hold their value. When EN returns high, the frame restarts with a snapshot.
- RESET: cnt=0, idx=3, dsnap=0, dpsnap=0, SEG=12'hFFF, FRAME=0. RESET has priority over EN.

## Timing
- SEG and FRAME are registered. SEG at cycle t+1 reflects cnt/idx/snapshot state at cycle t, giving one cycle of latency.
- Snapshot and first BLANK cycle coincide. BLANK_CYC >= 1 guarantees the snapshot is settled before the first DRIVE output.
- Frame period = 4·SCAN_DIV cycles. FRAME pulses exactly once per period, one cycle after the snapshot cycle.
- After RESET deasserts with EN=1:
  - The first snapshot occurs on the first cycle.
  - FRAME is high on the second cycle.
  - Digit 3 is first lit BLANK_CYC+1 cycles after reset release.
- A RESET or EN drop mid-slot takes effect at the next edge: SEG = 12'hFFF, with no partial digit carried over.
- Changes to DIGITS mid-frame are invisible until the next frame.

## Test plan
All scenarios use SCAN_DIV=8, BLANK_CYC=2 (32-cycle frame).

- Reset, EN=1, RESET=1 for 10 cycles -> SEG=12'hFFF and FRAME=0 throughout; after release, FRAME pulses at the 2nd cycle and every 32 cycles after.
- DIGITS=16'h1234, DP=0, LZ=0 -> per slot, 2 blank cycles at 12'hFFF followed by 6 drive cycles:
  - digit 3 drives 12'h7F9
  - digit 2 drives 12'hBA4
  - digit 1 drives 12'hDB0
  - digit 0 drives 12'hE99
- Same digits, DP=4'b0010 -> the digit 1 slot drives 12'hD30; the other digits are unchanged.
- LZ_SUPPRESS=1:
  - DIGITS=16'h0007 -> slots 3, 2, 1 stay 12'hFFF; slot 0 = 12'hEF8.
  - DIGITS=16'h0000 -> slot 0 = 12'hEC0.
  - DIGITS=16'h0400 -> slot 1 shows 12'hDC0 (zero is not leading).
- Snapshot: change DIGITS from 16'h1234 to 16'h5678 during the digit 2 slot -> the remainder of the frame still shows 2, 3, 4; the next frame shows 12'h792 on digit 3.
- Mid-scan abort: drop EN for 3 cycles during the digit 1 drive (or pulse RESET) -> SEG=12'hFFF at the next edge; on resume, FRAME pulses and the scan restarts at digit 3 after 2 blank cycles.
